// File: rtl/smpl_window_queue_if.sv
// rtl/smpl_window_queue_if.sv - sample write / window replay interface of smpl_window_queue
interface smpl_window_queue_if;
    logic               wrt_smpl;
    logic signed [15:0] smpl_in;
    logic               sequencing;
    logic signed [15:0] smpl_out;
    logic               ovf;

    modport master (
        output wrt_smpl, smpl_in,
        input  sequencing, smpl_out, ovf
    );

    modport slave (
        input  wrt_smpl, smpl_in,
        output sequencing, smpl_out, ovf
    );
endinterface

// File: rtl/smpl_window_queue.sv
// rtl/smpl_window_queue.sv - circular sample queue replaying a sliding DEPTH-sample window to the FIR
module smpl_window_queue #(
    parameter int AW    = 10,
    parameter int DEPTH = 1021
) (
    input  logic               clk,
    input  logic               rst_n,
    smpl_window_queue_if.slave bus
);
    localparam int            SIZE     = 1 << AW;
    localparam logic [AW-1:0] ONE      = 1;
    localparam logic [AW-1:0] CNT_FULL = {AW{1'b1}};
    localparam logic [AW-1:0] WIN_LEN  = AW'(DEPTH);
    localparam logic [AW-1:0] WIN_LAST = AW'(DEPTH - 1);

    typedef enum logic {IDLE, SEQ} state_t;
    state_t state, state_nxt;

    logic signed [15:0] mem [SIZE];
    logic [AW-1:0]      new_ptr, old_ptr, rd_ptr, cnt, seq_cnt;
    logic               sequencing_q, ovf_q;
    logic signed [15:0] smpl_out_q;
    logic               do_wr, do_drop, do_start, do_retire;

    always_comb begin
        state_nxt = state;
        do_wr     = bus.wrt_smpl && (cnt != CNT_FULL);
        do_drop   = bus.wrt_smpl && (cnt == CNT_FULL);
        do_start  = 1'b0;
        do_retire = 1'b0;
        case (state)
            IDLE: begin
                if (cnt >= WIN_LEN) begin
                    state_nxt = SEQ;
                    do_start  = 1'b1;
                end
            end
            SEQ: begin
                if (seq_cnt == WIN_LAST) begin
                    state_nxt = IDLE;
                    do_retire = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            new_ptr      <= '0;
            old_ptr      <= '0;
            rd_ptr       <= '0;
            cnt          <= '0;
            seq_cnt      <= '0;
            sequencing_q <= 1'b0;
            smpl_out_q   <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (do_wr) begin
                new_ptr <= new_ptr + ONE;
            end
            if (do_drop) begin
                ovf_q <= 1'b1;
            end
            // A write on the retire edge cancels the decrement, keeping cnt net unchanged.
            cnt <= cnt + AW'(do_wr) - AW'(do_retire);
            if (do_start) begin
                rd_ptr  <= old_ptr;
                seq_cnt <= '0;
            end
            if (state == SEQ) begin
                smpl_out_q   <= mem[rd_ptr];
                sequencing_q <= 1'b1;
                rd_ptr       <= rd_ptr + ONE;
                seq_cnt      <= seq_cnt + ONE;
            end else begin
                sequencing_q <= 1'b0;
            end
            if (do_retire) begin
                old_ptr <= old_ptr + ONE;
            end
        end
    end

    // At least two free slots remain, so a write can never land inside the window being read.
    always_ff @(posedge clk) begin
        if (rst_n && do_wr) begin
            mem[new_ptr] <= bus.smpl_in;
        end
    end

    assign bus.sequencing = sequencing_q;
    assign bus.smpl_out   = smpl_out_q;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_smpl_window_queue.sv
// tb/tb_smpl_window_queue.sv - scoreboard bench for smpl_window_queue window replay, overflow and reset
module tb_smpl_window_queue;
    localparam int AW    = 10;
    localparam int DEPTH = 1021;
    localparam int FULL  = (1 << AW) - 1;
    localparam int LIMIT = 12000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    smpl_window_queue_if bus ();

    smpl_window_queue #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int acc    = 0;
    int done   = 0;
    int pos    = 0;
    logic [15:0] stored [$];
    logic [15:0] exp_q [$];
    logic [15:0] exp_v;

    // Scoreboard: pops expected window samples while sequencing, then books any write
    // the DUT will sample on the next rising edge; each accepted sample beyond DEPTH-1
    // pushes the window ending at that sample.
    always @(negedge clk) begin
        if (bus.sequencing === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL seq_unexpected: sequencing=1 with no window due (windows done %0d)", done);
            end else begin
                exp_v = exp_q.pop_front();
                if (bus.smpl_out !== exp_v) begin
                    errors++;
                    $display("FAIL window_sample: smpl_out=%0d expected=%0d (window %0d pos %0d)",
                             $signed(bus.smpl_out), $signed(exp_v), done, pos);
                end
                pos++;
                if (pos == DEPTH) begin
                    pos = 0;
                    done++;
                end
            end
        end
        if (!rst_n) begin
            acc  = 0;
            done = 0;
            pos  = 0;
            stored.delete();
            exp_q.delete();
        end else if (bus.wrt_smpl === 1'b1 && (acc - done) < FULL) begin
            stored.push_back(bus.smpl_in);
            acc++;
            if (acc >= DEPTH) begin
                for (int i = acc - DEPTH; i < acc; i++) exp_q.push_back(stored[i]);
            end
        end
    end

    task automatic drive(input logic w, input logic [15:0] v);
        @(posedge clk);
        #1;
        bus.wrt_smpl = w;
        bus.smpl_in  = v;
    endtask

    task automatic wr(input logic [15:0] v);
        drive(1'b1, v);
        drive(1'b0, 16'h0000);
    endtask

    task automatic wait_idle(output logic timed_out);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.sequencing !== 1'b0) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        timed_out = (n >= LIMIT);
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        bus.wrt_smpl = 1'b0;
        bus.smpl_in  = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.sequencing !== 1'b0) begin
            errors++;
            $display("FAIL reset_sequencing: got %b want 0", bus.sequencing);
        end
        checks++;
        if (bus.smpl_out !== 16'sd0) begin
            errors++;
            $display("FAIL reset_smpl_out: got %0d want 0", $signed(bus.smpl_out));
        end
        checks++;
        if (bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b want 0", bus.ovf);
        end
    endtask

    task automatic test_fill;
        logic any_seq;
        any_seq = 1'b0;
        for (int v = 1; v < DEPTH; v++) begin
            drive(1'b1, 16'(v));
            any_seq |= (bus.sequencing !== 1'b0);
            for (int k = 0; k < 9; k++) begin
                drive(1'b0, 16'h0000);
                any_seq |= (bus.sequencing !== 1'b0);
            end
        end
        checks++;
        if (any_seq !== 1'b0) begin
            errors++;
            $display("FAIL fill_no_seq: sequencing seen=%b want 0 before full window", any_seq);
        end
        checks++;
        if (bus.smpl_out !== 16'sd0) begin
            errors++;
            $display("FAIL fill_smpl_out: got %0d want 0", $signed(bus.smpl_out));
        end
        checks++;
        if (bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL fill_ovf: got %b want 0", bus.ovf);
        end
    endtask

    task automatic test_first_window;
        int first, last, hi;
        logic to;
        first = -1;
        last  = -1;
        hi    = 0;
        drive(1'b1, 16'(DEPTH));
        drive(1'b0, 16'h0000);
        for (int k = 0; k <= DEPTH + 3; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (bus.sequencing === 1'b1) begin
                if (first < 0) first = k;
                last = k;
                hi++;
            end
        end
        checks++;
        if (first != 2) begin
            errors++;
            $display("FAIL first_latency: first high after edge E%0d want E2", first);
        end
        checks++;
        if (hi != DEPTH || last != DEPTH + 1) begin
            errors++;
            $display("FAIL first_length: high %0d cycles ending E%0d want %0d ending E%0d",
                     hi, last, DEPTH, DEPTH + 1);
        end
        checks++;
        if (bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL first_ovf: got %b want 0", bus.ovf);
        end
        wait_idle(to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL first_idle: window still pending after %0d cycles", LIMIT);
        end
    endtask

    task automatic test_slide_wrap;
        logic to, any_to;
        any_to = 1'b0;
        for (int v = DEPTH + 1; v <= DEPTH + 5; v++) begin
            wr(16'(v));
            wait_idle(to);
            any_to |= to;
        end
        checks++;
        if (any_to) begin
            errors++;
            $display("FAIL slide_idle: replay did not finish within %0d cycles", LIMIT);
        end
        checks++;
        if (done != 6) begin
            errors++;
            $display("FAIL slide_windows: got %0d windows want 6", done);
        end
        checks++;
        if (bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL slide_ovf: got %b want 0", bus.ovf);
        end
    endtask

    task automatic test_back_to_back;
        int n, cur_len;
        int his [$];
        int los [$];
        logic cur, s, to;
        wr(16'(DEPTH + 6));
        n = 0;
        while (bus.sequencing !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 10) begin
            errors++;
            $display("FAIL b2b_start: sequencing never rose, got %b want 1", bus.sequencing);
        end
        cur     = 1'b1;
        cur_len = 1;
        for (int i = 0; i < 3 * DEPTH + 10; i++) begin
            drive(i == 5 || i == 10, (i == 5) ? 16'(DEPTH + 7) : 16'(DEPTH + 8));
            s = (bus.sequencing === 1'b1);
            if (s == cur) begin
                cur_len++;
            end else begin
                if (cur) his.push_back(cur_len);
                else     los.push_back(cur_len);
                cur     = s;
                cur_len = 1;
            end
        end
        if (cur) his.push_back(cur_len);
        drive(1'b0, 16'h0000);
        checks++;
        if (his.size() != 3) begin
            errors++;
            $display("FAIL b2b_windows: got %0d high runs want 3", his.size());
        end
        for (int i = 0; i < his.size() && i < 3; i++) begin
            checks++;
            if (his[i] != DEPTH) begin
                errors++;
                $display("FAIL b2b_run_len: run %0d high %0d cycles want %0d", i, his[i], DEPTH);
            end
        end
        for (int i = 0; i < los.size() && i < 2; i++) begin
            checks++;
            if (los[i] != 1) begin
                errors++;
                $display("FAIL b2b_gap: gap %0d low %0d cycles want 1", i, los[i]);
            end
        end
        checks++;
        if (bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ovf: got %b want 0", bus.ovf);
        end
        wait_idle(to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL b2b_idle: windows still pending after %0d cycles", LIMIT);
        end
    endtask

    task automatic test_overflow;
        int d0;
        logic to;
        d0 = done;
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, (i == 0) ? 16'h8000 : (i == 1) ? 16'h7fff : 16'(100 + i));
        end
        drive(1'b0, 16'h0000);
        checks++;
        if (bus.ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got %b want 1", bus.ovf);
        end
        wait_idle(to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL ovf_idle: windows still pending after %0d cycles", LIMIT);
        end
        checks++;
        if (done - d0 != 3) begin
            errors++;
            $display("FAIL ovf_windows: got %0d windows want 3", done - d0);
        end
        checks++;
        if (bus.ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b want 1", bus.ovf);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        logic to;
        wr(16'd1234);
        n = 0;
        while (bus.sequencing !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (100) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.sequencing !== 1'b0) begin
            errors++;
            $display("FAIL midrst_sequencing: got %b want 0", bus.sequencing);
        end
        checks++;
        if (bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ovf: got %b want 0", bus.ovf);
        end
        checks++;
        if (bus.smpl_out !== 16'sd0) begin
            errors++;
            $display("FAIL midrst_smpl_out: got %0d want 0", $signed(bus.smpl_out));
        end
        for (int v = 0; v < DEPTH; v++) drive(1'b1, 16'(5000 + v));
        drive(1'b0, 16'h0000);
        wait_idle(to);
        checks++;
        if (to || done != 1) begin
            errors++;
            $display("FAIL refill_window: got %0d windows (timeout %b) want 1", done, to);
        end
        checks++;
        if (bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL refill_ovf: got %b want 0", bus.ovf);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_first_window();
        test_slide_wrap();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
